wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Merges two producers onto that port:
  - the in-order pipeline writeback (ALU/load results), which cannot be back-pressured;
  - a long-latency unit (mul/div), which uses a valid/ready handshake.
- Buffers long-latency results in a small FIFO.
- Keeps a pending-write scoreboard so decode can detect RAW hazards on in-flight long-latency destinations.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive blocked cycles before a pipeline bubble is requested

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wb_valid_i  in  1  pipeline writeback request
- wb_addr_i  in  ADDR_W  pipeline destination register
- wb_data_i  in  DATA_W  pipeline result
- md_valid_i  in  1  long-latency result valid
- md_ready_o  out  1  FIFO can accept a result
- md_addr_i  in  ADDR_W  long-latency destination register
- md_data_i  in  DATA_W  long-latency result
- issue_i  in  1  long-latency op issued this cycle
- issue_addr_i  in  ADDR_W  destination of issued op
- rs1_addr_i  in  ADDR_W  decode source 1
- rs2_addr_i  in  ADDR_W  decode source 2
- rs1_pending_o  out  1  rs1 has an outstanding long-latency write
- rs2_pending_o  out  1  rs2 has an outstanding long-latency write
- stall_o  out  1  request one pipeline writeback bubble
- writereg_addr_o  out  ADDR_W  register file write address
- data_o  out  DATA_W  register file write data
- data_write_o  out  1  register file write enable

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - On reset: writereg_addr_o=0, data_o=0, data_write_o=0, stall_o=0.
  - FIFO emptied, so md_ready_o=1 once out of reset.
  - Scoreboard all zero; starvation counter 0.
  - Reset mid-operation discards buffered results and pending bits.
- Write port: registered on posedge.
  - An accepted request appears on writereg_addr_o/data_o/data_write_o one cycle later.
  - Hold time is one cycle, so the register file's negedge write samples it mid-cycle.
  - Any request addressed to x0 is accepted but produces data_write_o=0.
- Priority per cycle:
  - wb_valid_i=1: the pipeline request drives the port. It always wins and is never dropped.
  - wb_valid_i=0 and FIFO non-empty: the FIFO head drives the port and is popped.
  - Otherwise: data_write_o=0 next cycle; addr/data hold their previous values.
- FIFO:
  - Push when md_valid_i && md_ready_o.
  - md_ready_o = !full, combinational from registered occupancy.
  - Push and pop in the same cycle while full is illegal, because ready is already low. Same-cycle push and pop at any other occupancy keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: an empty FIFO plus a push gives the earliest write port output two cycles after push.
- Scoreboard (2**ADDR_W bits):
  - issue_i sets pending[issue_addr_i].
  - A FIFO pop clears pending[head addr].
  - Set and clear on the same address in the same cycle: set wins.
  - Address 0 is never set.
  - Pipeline writebacks do not touch the scoreboard.
  - rsN_pending_o = pending[rsN_addr_i], combinational. Decode uses these to stall.
- Starvation:
  - The counter increments each cycle with FIFO non-empty and wb_valid_i=1.
  - It resets to 0 on any pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT, stall_o=1 (registered) until the next pop.
  - If the pipeline still presents wb_valid_i while stall_o=1, the pipeline still wins. The counter stays saturated and stall_o stays high.

Decomposition:
- Shared package: ADDR_W/DATA_W constants, REG_ZERO address constant, write-port bundle typedef {addr, data, we}.
- One natural sub-module, wb_result_fifo: synchronous FIFO with count, full, empty, push, pop. It is instantiated once; arbitration, scoreboard and starvation logic stay in the top.

Test Plan:
- Reset, then wb_valid_i=1, addr=5, data=0xDEADBEEF for 1 cycle -> next cycle writereg_addr_o=5, data_o=0xDEADBEEF, data_write_o=1; the cycle after, data_write_o=0.
- issue_i addr=7, then md push addr=7 data=0x12 with wb idle -> rs1_pending_o=1 for rs1_addr_i=7 from the cycle after issue; write port shows 7/0x12 two cycles after push; pending clears on the pop cycle.
- Three md pushes back-to-back with wb_valid_i held 1 -> md_ready_o=0 after 2 accepted; third held; after 8 blocked cycles stall_o=1; drop wb_valid_i -> entries drain in order, stall_o falls after first pop.
- Same cycle: issue_i addr=9 and FIFO pop of addr=9 -> pending[9] remains 1.
- wb_valid_i addr=0 data=0xFFFFFFFF -> data_write_o stays 0; md result to x0 -> popped, no write, no scoreboard change.
- Assert reset_n=0 asynchronously with FIFO holding 2 entries and pending bits set -> all outputs 0 immediately, md_ready_o=1 after release, no stale writes appear.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The write-port bundle is what the arbiter registers toward the register file.
package wb_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
    } wr_port_t;

    // x0 is hard-wired zero, so writes to it are swallowed at the port
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency {addr, data} results.
// The head entry is readable combinationally so it can be popped onto the port in the same cycle.
module wb_result_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // storage is not reset; occupancy alone defines validity
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && wr_ptr_reg == PW'(gi)) begin
                mem[gi] <= {push_addr, push_data};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign {head_addr, head_data} = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency
// results wait in a FIFO, a scoreboard flags in-flight destinations, and starvation requests a bubble.
module wb_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              md_valid_i,
    output logic              md_ready_o,
    input  logic [ADDR_W-1:0] md_addr_i,
    input  logic [DATA_W-1:0] md_data_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs1_pending_o,
    output logic              rs2_pending_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] writereg_addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_write_o
);

    import wb_arbiter_pkg::*;

    localparam int NREG = 2**ADDR_W;
    localparam int SW   = $clog2(STARVE_LIMIT+1);
    localparam int CW   = $clog2(FIFO_DEPTH+1);

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_busy;

    wr_port_t          port_reg;
    wr_port_t          port_next;
    logic [SW-1:0]     starve_reg;
    logic [SW-1:0]     starve_next;
    logic              stall_reg;
    logic [NREG-1:0]   pending_reg;

    assign md_ready_o = !fifo_full;
    assign push       = md_valid_i && md_ready_o;
    assign pop        = !wb_valid_i && !fifo_empty;
    assign fifo_busy  = (fifo_count != '0);

    wb_result_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_addr (md_addr_i),
        .push_data (md_data_i),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        port_next    = port_reg;
        port_next.we = 1'b0;
        if (wb_valid_i) begin
            port_next.addr = wb_addr_i;
            port_next.data = wb_data_i;
            port_next.we   = is_writable(wb_addr_i);
        end else if (pop) begin
            port_next.addr = head_addr;
            port_next.data = head_data;
            port_next.we   = is_writable(head_addr);
        end
    end

    // counts only cycles where a buffered result is blocked by the pipeline
    always_comb begin
        starve_next = starve_reg;
        if (pop || !fifo_busy) begin
            starve_next = '0;
        end else if (wb_valid_i && starve_reg != SW'(STARVE_LIMIT)) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_reg   <= '0;
            starve_reg <= '0;
            stall_reg  <= 1'b0;
        end else begin
            port_reg   <= port_next;
            starve_reg <= starve_next;
            stall_reg  <= (starve_next == SW'(STARVE_LIMIT));
        end
    end

    // a fresh issue must win over the retirement of an older op to the same register
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
        if (gi == 0) begin : g_zero
            assign pending_reg[gi] = 1'b0;
        end else begin : g_bit
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_i && (issue_addr_i == ADDR_W'(gi));
            assign clr_bit = pop && (head_addr == ADDR_W'(gi));
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pending_reg[gi] <= 1'b0;
                end else if (set_bit) begin
                    pending_reg[gi] <= 1'b1;
                end else if (clr_bit) begin
                    pending_reg[gi] <= 1'b0;
                end
            end
        end
    end

    assign rs1_pending_o   = pending_reg[rs1_addr_i];
    assign rs2_pending_o   = pending_reg[rs2_addr_i];
    assign stall_o         = stall_reg;
    assign writereg_addr_o = port_reg.addr;
    assign data_o          = port_reg.data;
    assign data_write_o    = port_reg.we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed stimulus for wb_arbiter, checked each cycle against
// a queue-based reference model of the arbitration, scoreboard and starvation rules.
module tb_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wb_valid_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_data_i;
    logic          md_valid_i;
    logic          md_ready_o;
    logic [AW-1:0] md_addr_i;
    logic [DW-1:0] md_data_i;
    logic          issue_i;
    logic [AW-1:0] issue_addr_i;
    logic [AW-1:0] rs1_addr_i;
    logic [AW-1:0] rs2_addr_i;
    logic          rs1_pending_o;
    logic          rs2_pending_o;
    logic          stall_o;
    logic [AW-1:0] writereg_addr_o;
    logic [DW-1:0] data_o;
    logic          data_write_o;

    wb_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wb_valid_i      (wb_valid_i),
        .wb_addr_i       (wb_addr_i),
        .wb_data_i       (wb_data_i),
        .md_valid_i      (md_valid_i),
        .md_ready_o      (md_ready_o),
        .md_addr_i       (md_addr_i),
        .md_data_i       (md_data_i),
        .issue_i         (issue_i),
        .issue_addr_i    (issue_addr_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs1_pending_o   (rs1_pending_o),
        .rs2_pending_o   (rs2_pending_o),
        .stall_o         (stall_o),
        .writereg_addr_o (writereg_addr_o),
        .data_o          (data_o),
        .data_write_o    (data_write_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    bit            pend[32];
    int            starve;
    bit            m_stall;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_we;
    bit            md_acc;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        starve  = 0;
        m_stall = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_we    = 1'b0;
    endtask

    task automatic idle_inputs();
        wb_valid_i   = 1'b0;
        wb_addr_i    = '0;
        wb_data_i    = '0;
        md_valid_i   = 1'b0;
        md_addr_i    = '0;
        md_data_i    = '0;
        issue_i      = 1'b0;
        issue_addr_i = '0;
    endtask

    task automatic check_outputs();
        chk("we", 64'(data_write_o), 64'(m_we));
        if (m_we) begin
            chk("addr", 64'(writereg_addr_o), 64'(m_addr));
            chk("data", 64'(data_o), 64'(m_data));
        end
        chk("stall", 64'(stall_o), 64'(m_stall));
        chk("md_ready", 64'(md_ready_o), 64'(q.size() < DEPTH));
        chk("rs1_pend", 64'(rs1_pending_o), 64'(pend[rs1_addr_i]));
        chk("rs2_pend", 64'(rs2_pending_o), 64'(pend[rs2_addr_i]));
    endtask

    // Inputs are set by the caller just after a falling edge; advance one full clock.
    task automatic cycle();
        bit   ready;
        bit   push;
        bit   pop;
        ent_t h;
        ent_t n;
        #1;
        check_outputs();
        ready = (q.size() < DEPTH);
        push  = md_valid_i && ready;
        pop   = !wb_valid_i && (q.size() > 0);
        if (pop) h = q[0];
        if (wb_valid_i) begin
            m_addr = wb_addr_i;
            m_data = wb_data_i;
            m_we   = (wb_addr_i != 0);
        end else if (pop) begin
            m_addr = h.a;
            m_data = h.d;
            m_we   = (h.a != 0);
        end else begin
            m_we = 1'b0;
        end
        if (pop) pend[h.a] = 1'b0;
        if (issue_i && issue_addr_i != 0) pend[issue_addr_i] = 1'b1;
        if (pop || q.size() == 0) starve = 0;
        else if (wb_valid_i && starve < LIMIT) starve++;
        m_stall = (starve == LIMIT);
        if (pop) void'(q.pop_front());
        if (push) begin
            n.a = md_addr_i;
            n.d = md_data_i;
            q.push_back(n);
        end
        md_acc = push;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        idle_inputs();
        rs1_addr_i = '0;
        rs2_addr_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // single pipeline writeback
        wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
        cycle();
        wb_valid_i = 1'b0;
        chk("t1_addr", 64'(writereg_addr_o), 64'd5);
        chk("t1_data", 64'(data_o), 64'hDEADBEEF);
        chk("t1_we", 64'(data_write_o), 64'd1);
        cycle();
        chk("t1_we_drop", 64'(data_write_o), 64'd0);

        // issue then long-latency result, wb idle
        rs1_addr_i = 5'd7;
        issue_i = 1'b1; issue_addr_i = 5'd7;
        cycle();
        issue_i = 1'b0;
        md_valid_i = 1'b1; md_addr_i = 5'd7; md_data_i = 32'h12;
        cycle();
        md_valid_i = 1'b0;
        repeat (3) cycle();
        chk("t2_clear", 64'(rs1_pending_o), 64'd0);

        // three pushes while pipeline hogs the port, then drain
        begin
            ent_t pendq[$];
            ent_t e;
            for (int i = 0; i < 3; i++) begin
                e.a = AW'(10 + i);
                e.d = 32'hA000 + DW'(i);
                pendq.push_back(e);
            end
            for (int c = 0; c < 13; c++) begin
                wb_valid_i = 1'b1;
                wb_addr_i  = AW'($urandom_range(1, 31));
                wb_data_i  = $urandom;
                md_valid_i = (pendq.size() > 0);
                if (pendq.size() > 0) begin
                    md_addr_i = pendq[0].a;
                    md_data_i = pendq[0].d;
                end
                cycle();
                if (md_acc) void'(pendq.pop_front());
            end
            chk("t3_stall", 64'(stall_o), 64'd1);
            chk("t3_ready", 64'(md_ready_o), 64'd0);
            wb_valid_i = 1'b0;
            for (int c = 0; c < 6; c++) begin
                md_valid_i = (pendq.size() > 0);
                if (pendq.size() > 0) begin
                    md_addr_i = pendq[0].a;
                    md_data_i = pendq[0].d;
                end
                cycle();
                if (md_acc) void'(pendq.pop_front());
            end
            md_valid_i = 1'b0;
        end

        // issue and pop of the same register in one cycle
        rs1_addr_i = 5'd9;
        issue_i = 1'b1; issue_addr_i = 5'd9;
        cycle();
        issue_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'h1;
        md_valid_i = 1'b1; md_addr_i = 5'd9; md_data_i = 32'h99;
        cycle();
        md_valid_i = 1'b0; wb_valid_i = 1'b0;
        issue_i = 1'b1; issue_addr_i = 5'd9;
        cycle();
        issue_i = 1'b0;
        cycle();
        chk("t4_setwins", 64'(rs1_pending_o), 64'd1);

        // writes to x0 from both producers
        wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFFFFFF;
        cycle();
        wb_valid_i = 1'b0;
        md_valid_i = 1'b1; md_addr_i = 5'd0; md_data_i = 32'h55;
        cycle();
        md_valid_i = 1'b0;
        repeat (3) cycle();

        // asynchronous reset with two buffered results and pending bits
        rs1_addr_i = 5'd3; rs2_addr_i = 5'd4;
        issue_i = 1'b1; issue_addr_i = 5'd3;
        cycle();
        issue_addr_i = 5'd4;
        wb_valid_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'h22;
        md_valid_i = 1'b1; md_addr_i = 5'd3; md_data_i = 32'h33;
        cycle();
        issue_i = 1'b0;
        md_addr_i = 5'd4; md_data_i = 32'h44;
        cycle();
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_we", 64'(data_write_o), 64'd0);
        chk("rst_addr", 64'(writereg_addr_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_rs1", 64'(rs1_pending_o), 64'd0);
        chk("rst_rs2", 64'(rs2_pending_o), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) cycle();

        // randomized traffic in phases of varying pipeline pressure
        for (int c = 0; c < 3000; c++) begin
            int p;
            p = ((c / 40) % 3 == 0) ? 10 : (((c / 40) % 3 == 1) ? 50 : 95);
            wb_valid_i = ($urandom_range(0, 99) < p);
            wb_addr_i  = AW'($urandom);
            wb_data_i  = $urandom;
            if (!md_valid_i && $urandom_range(0, 99) < 40) begin
                md_valid_i = 1'b1;
                md_addr_i  = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
                md_data_i  = $urandom;
            end
            issue_i      = ($urandom_range(0, 3) == 0);
            issue_addr_i = AW'($urandom);
            rs1_addr_i   = AW'($urandom);
            rs2_addr_i   = AW'($urandom);
            cycle();
            if (md_acc) md_valid_i = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
